// File: rtl/lsu_if.sv
// lsu_if -- memory-side bus between the LSU and the data memory/fabric.
//   master (LSU)  : drives bus_req/bus_write/bus_addr/bus_wdata/bus_byteen,
//                   receives bus_ready/bus_rvalid/bus_rdata.
//   slave (memory): the mirror image.
interface lsu_if;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_write, bus_addr, bus_wdata, bus_byteen,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_write, bus_addr, bus_wdata, bus_byteen,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// lsu -- load/store unit. Captures one aligned load/store from execute,
// issues it on the memory bus one cycle later, and for loads formats the
// returned word into lsu_readdata.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lsu_mem_read/lsu_mem_write    request from execute
//   lsu_mem_opcode[2:0]           [1:0] size (00 B, 01 H, 1x W), [2] zero-extend
//   lsu_address, lsu_writedata    byte address, right-aligned store data
//   lsu_ex_stall, lsu_flush       block capture of the execute request
//   lsu_exception_*_misaligned    combinational misalignment flags
//   lsu_stall                     access in flight, pipeline holds
//   lsu_readdata                  formatted load result (held until next load)
//   bus                           memory bus (lsu_if.master)
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_mem_read,
  input  logic        lsu_mem_write,
  input  logic [2:0]  lsu_mem_opcode,
  input  logic [31:0] lsu_address,
  input  logic [31:0] lsu_writedata,
  input  logic        lsu_ex_stall,
  input  logic        lsu_flush,
  output logic        lsu_exception_load_addr_misaligned,
  output logic        lsu_exception_store_addr_misaligned,
  output logic        lsu_stall,
  output logic [31:0] lsu_readdata,
  lsu_if.master       bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA} state_t;

  state_t      state_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  op_q;
  logic [3:0]  byteen_q;
  logic [31:0] wdata_q;
  logic [31:0] readdata_q;

  logic        misaligned;
  logic        capture;
  logic [3:0]  byteen_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] readdata_d;

  // Half needs addr[0]=0; word (size 10 or 11) needs addr[1:0]=0.
  assign misaligned = ((lsu_mem_opcode[1:0] == 2'b01) & lsu_address[0]) |
                      (lsu_mem_opcode[1] & (|lsu_address[1:0]));

  assign lsu_exception_load_addr_misaligned  = lsu_mem_read  & misaligned;
  assign lsu_exception_store_addr_misaligned = lsu_mem_write & misaligned;

  assign capture = (lsu_mem_read | lsu_mem_write) & ~misaligned &
                   ~lsu_ex_stall & ~lsu_flush;

  always_comb begin
    byteen_d = 4'b1111;
    wdata_d  = lsu_writedata;
    case (lsu_mem_opcode[1:0])
      2'b00: begin
        byteen_d = 4'b0001 << lsu_address[1:0];
        wdata_d  = {4{lsu_writedata[7:0]}};
      end
      2'b01: begin
        byteen_d = 4'b0011 << {lsu_address[1], 1'b0};
        wdata_d  = {2{lsu_writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0; halfwords are 2-aligned so the
  // same byte-offset shift works for both sizes.
  assign lane = bus.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    readdata_d = bus.bus_rdata;
    case (op_q[1:0])
      2'b00:   readdata_d = {{24{~op_q[2] & lane[7]}},  lane[7:0]};
      2'b01:   readdata_d = {{16{~op_q[2] & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  // Captured request is frozen in *_q, so the bus fields stay stable
  // through REQ regardless of what execute does meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      off_q      <= '0;
      op_q       <= '0;
      byteen_q   <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (capture) begin
          state_q  <= S_REQ;
          write_q  <= lsu_mem_write;
          addr_q   <= {lsu_address[31:2], 2'b00};
          off_q    <= lsu_address[1:0];
          op_q     <= lsu_mem_opcode;
          byteen_q <= byteen_d;
          wdata_q  <= wdata_d;
        end
        S_REQ: if (bus.bus_ready)
          state_q <= write_q ? S_IDLE : S_RDATA;
        S_RDATA: if (bus.bus_rvalid) begin
          state_q    <= S_IDLE;
          readdata_q <= readdata_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_stall      = (state_q != S_IDLE);
  assign lsu_readdata   = readdata_q;
  assign bus.bus_req    = (state_q == S_REQ);
  assign bus.bus_write  = write_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.bus_byteen = byteen_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ex_stall, flush;
  logic [2:0]  opcode;
  logic [31:0] address, writedata;
  logic        lmis, smis, stall;
  logic [31:0] readdata;

  lsu_if bus();

  lsu dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .lsu_mem_read                        (mem_read),
    .lsu_mem_write                       (mem_write),
    .lsu_mem_opcode                      (opcode),
    .lsu_address                         (address),
    .lsu_writedata                       (writedata),
    .lsu_ex_stall                        (ex_stall),
    .lsu_flush                           (flush),
    .lsu_exception_load_addr_misaligned  (lmis),
    .lsu_exception_store_addr_misaligned (smis),
    .lsu_stall                           (stall),
    .lsu_readdata                        (readdata),
    .bus                                 (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
    if (op[1]) return 4'hf;
    if (op[0]) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] op, input logic [31:0] wd);
    if (op[1]) return wd;
    if (op[0]) return {wd[15:0], wd[15:0]};
    return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    if (op[1]) return d;
    if (op[0]) begin
      h = a[1] ? d[31:16] : d[15:0];
      return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
    end
    case (a[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; ex_stall = 0; flush = 0;
    bus.bus_ready = 0; bus.bus_rvalid = 0;
  endtask

  // One full transaction. Called right after a negedge. noise=1 raises
  // flush, ex_stall and a stray rvalid while the request sits in REQ.
  task automatic do_txn(input logic wr, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly, input logic noise);
    exp_t e, g;
    int   nst;
    mem_read = ~wr; mem_write = wr; opcode = op; address = a; writedata = wd;
    e.wr = wr; e.addr = {a[31:2], 2'b00}; e.be = exp_be(op, a); e.wd = exp_wd(op, wd);
    e.rd = wr ? last_rd : exp_rd(op, a, rdata);
    exp_q.push_back(e);
    #1;
    chk("mis_flags", {30'h0, lmis, smis}, 32'h0);
    chk("req_at_capture", {31'h0, bus.bus_req}, 32'h0);
    @(negedge clk);
    idle_inputs();
    g = exp_q.pop_front();
    nst = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      flush = noise; ex_stall = noise; bus.bus_rvalid = noise;
      bus.bus_rdata = 32'hDEAD_BEEF;
      bus.bus_ready = (i == rdy_dly);
      chk("bus_req",  {31'h0, bus.bus_req},   32'h1);
      chk("bus_wr",   {31'h0, bus.bus_write}, {31'h0, g.wr});
      chk("bus_addr", bus.bus_addr,           g.addr);
      chk("bus_be",   {28'h0, bus.bus_byteen}, {28'h0, g.be});
      if (g.wr) chk("bus_wdata", bus.bus_wdata, g.wd);
      if (stall) nst++;
      @(negedge clk);
    end
    idle_inputs();
    if (!g.wr) begin
      for (int i = 0; i <= rv_dly; i++) begin
        chk("rdata_noreq", {31'h0, bus.bus_req}, 32'h0);
        bus.bus_rvalid = (i == rv_dly);
        bus.bus_rdata  = (i == rv_dly) ? rdata : ~rdata;
        if (stall) nst++;
        @(negedge clk);
      end
      idle_inputs();
    end
    chk("stall_cycles", nst, wr ? rdy_dly + 1 : rdy_dly + rv_dly + 2);
    chk("stall_end",    {31'h0, stall}, 32'h0);
    chk("readdata",     readdata, g.rd);
    last_rd = g.rd;
  endtask

  // Request that must not be captured; flags checked combinationally.
  task automatic no_capture(input logic rd, input logic wr, input logic [2:0] op,
                            input logic [31:0] a, input logic st, input logic fl,
                            input logic exp_l, input logic exp_s);
    mem_read = rd; mem_write = wr; opcode = op; address = a; writedata = 32'h5555_AAAA;
    ex_stall = st; flush = fl;
    #1;
    chk("lmis", {31'h0, lmis}, {31'h0, exp_l});
    chk("smis", {31'h0, smis}, {31'h0, exp_s});
    @(negedge clk);
    idle_inputs();
    chk("nocap_req",   {31'h0, bus.bus_req}, 32'h0);
    chk("nocap_stall", {31'h0, stall},       32'h0);
    @(negedge clk);
    chk("nocap_req2",  {31'h0, bus.bus_req}, 32'h0);
  endtask

  initial begin
    rst = 1; opcode = 0; address = 0; writedata = 0; bus.bus_rdata = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req",   {31'h0, bus.bus_req}, 32'h0);
    rst = 0;
    @(negedge clk);
    chk("rst_rd",    readdata, 32'h0);
    chk("rst_wr",    {31'h0, bus.bus_write}, 32'h0);
    chk("rst_addr",  bus.bus_addr, 32'h0);
    chk("rst_wdata", bus.bus_wdata, 32'h0);
    chk("rst_be",    {28'h0, bus.bus_byteen}, 32'h0);

    // LB 0x103 -> 0xFFFFFF80
    do_txn(0, 3'b000, 32'h103, 0, 32'h80_123456, 0, 0, 0);
    chk("lb_val", readdata, 32'hFFFF_FF80);
    // SH 0x202, ready late 3 cycles
    do_txn(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 3, 0, 0);
    chk("sh_keep", readdata, 32'hFFFF_FF80);
    // misaligned
    no_capture(1, 0, 3'b010, 32'h1001, 0, 0, 1, 0);
    no_capture(0, 1, 3'b010, 32'h1002, 0, 0, 0, 1);
    no_capture(1, 0, 3'b001, 32'h1003, 0, 0, 1, 0);
    no_capture(0, 1, 3'b011, 32'h1003, 0, 0, 0, 1);
    // LHU 0x6, rvalid 5 cycles after ready
    do_txn(0, 3'b101, 32'h6, 0, 32'h8001_7777, 0, 4, 0);
    chk("lhu_val", readdata, 32'h0000_8001);
    // flush / stall blocking capture; flush in REQ ignored
    no_capture(1, 0, 3'b010, 32'h400, 0, 1, 0, 0);
    no_capture(1, 0, 3'b010, 32'h400, 1, 0, 0, 0);
    do_txn(0, 3'b010, 32'h400, 0, 32'hCAFE_F00D, 2, 1, 1);
    do_txn(1, 3'b000, 32'h401, 32'h0000_00A5, 0, 1, 0, 1);
    // stray rvalid in IDLE
    bus.bus_rvalid = 1; bus.bus_rdata = 32'h1111_1111;
    @(negedge clk);
    idle_inputs();
    chk("stray_rvalid", readdata, last_rd);

    // random aligned traffic
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (op[1]) a[1:0] = 2'b00;
      else if (op[0]) a[0] = 1'b0;
      do_txn(1'($urandom_range(0, 1)), op, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset while in RDATA, then a late rvalid
    mem_read = 1; opcode = 3'b010; address = 32'h800;
    @(negedge clk);
    idle_inputs();
    bus.bus_ready = 1;
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_req",   {31'h0, bus.bus_req}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_rd",    readdata, 32'h0);
    bus.bus_rvalid = 1; bus.bus_rdata = 32'h7777_7777;
    @(negedge clk);
    idle_inputs();
    chk("late_rv_rd",    readdata, 32'h0);
    chk("late_rv_stall", {31'h0, stall}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  clock; all state SHALL update on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 lsu_mem_read  in  1  load request from execute stage.
REQ-004 lsu_mem_write  in  1  store request from execute stage.
REQ-005 lsu_mem_opcode  in  3  [1:0] 00 byte, 01 half, 10/11 word; [2] zero-extend load.
REQ-006 lsu_address  in  32  byte address.
REQ-007 lsu_writedata  in  32  store data, right-aligned.
REQ-008 lsu_ex_stall  in  1  execute stage held; request SHALL NOT be captured.
REQ-009 lsu_flush  in  1  kill execute-stage request; SHALL NOT be captured.
REQ-010 lsu_exception_load_addr_misaligned  out  1  combinational misaligned-load flag.
REQ-011 lsu_exception_store_addr_misaligned  out  1  combinational misaligned-store flag.
REQ-012 lsu_stall  out  1  memory access in progress; pipeline SHALL hold.
REQ-013 lsu_readdata  out  32  formatted load result, registered.
REQ-014 bus_req  out  1  bus request, held until bus_ready.
REQ-015 bus_write  out  1  1 store, 0 load.
REQ-016 bus_addr  out  32  word address ({addr[31:2],2'b00}).
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_byteen  out  4  byte enables.
REQ-019 bus_ready  in  1  request accepted this cycle.
REQ-020 bus_rvalid  in  1  read data valid, 1+ cycles after accept.
REQ-021 bus_rdata  in  32  read data word.

Function
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; load flag = mem_read & misaligned; store flag = mem_write & misaligned; no state dependence.
REQ-023 States: IDLE, REQ, RDATA; encoding free.
REQ-024 IDLE capture when (mem_read|mem_write) & ~misaligned & ~lsu_ex_stall & ~lsu_flush: register write flag, word address, addr[1:0], opcode, byteen, wdata; next state REQ.
REQ-025 Misaligned, flushed, stalled or absent requests SHALL leave FSM in IDLE with no bus activity.
REQ-026 REQ: bus_req=1 and all bus_* outputs stable until bus_ready; on bus_ready write -> IDLE, read -> RDATA.
REQ-027 RDATA: bus_req=0; on bus_rvalid register formatted data into lsu_readdata, -> IDLE.
REQ-028 bus_rvalid outside RDATA SHALL be ignored.
REQ-029 lsu_stall = (state!=IDLE), registered-state decode; minimum store latency 1 stall cycle, load 2.
REQ-030 Byteen: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-031 wdata: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
REQ-032 Load format: select lane by captured addr[1:0]; byte/half sign-extended when opcode[2]=0, zero-extended when 1; word as-is.
REQ-033 lsu_readdata SHALL hold its value until the next load completes; stores do not change it.
REQ-034 lsu_flush/lsu_ex_stall in REQ or RDATA SHALL be ignored; an accepted-by-FSM transaction always completes.
REQ-035 bus_req SHALL never assert in the same cycle as capture (one-cycle registered issue).

Reset
REQ-036 rst SHALL force IDLE, lsu_readdata=0, bus_req=0, bus_write=0, bus_addr=0, bus_wdata=0, bus_byteen=0, lsu_stall=0.
REQ-037 rst mid-transaction SHALL abandon it (bus_req low next cycle); late bus_rvalid ignored.

Verification
REQ-038 LB addr=0x103, rdata=0x80xxxxxx, ready+rvalid next cycles -> byteen=1000, bus_addr=0x100, readdata=0xFFFFFF80, stall 2 cycles.
REQ-039 SH addr=0x202, wd=0x1234ABCD, bus_ready held low 3 cycles -> bus_req/addr/byteen=1100/wdata=0xABCDABCD stable 4 cycles, stall 4 cycles, readdata unchanged.
REQ-040 LW addr=0x1001 -> load misaligned flag=1 same cycle, no bus_req, stall=0; SW 0x1002 -> store flag=1, no bus_req.
REQ-041 LHU addr=0x6, rdata=0x8001xxxx, rvalid 5 cycles after ready -> readdata=0x00008001, stall throughout RDATA.
REQ-042 lsu_flush=1 with valid LW -> no capture; lsu_flush=1 during REQ -> transaction completes normally.
REQ-043 rst asserted in RDATA then rvalid -> state IDLE, readdata=0, stall=0.
